manchester_receiver: RTL and testbench

//  Receive end of the Manchester frame link driven by the CPLD transmitter. Oversamples i_rx, decodes

---
 rtl/manchester_receiver_pkg.sv | 40 ++++
 rtl/manchester_receiver_bit_decoder.sv | 85 ++++++++
 rtl/manchester_receiver.sv | 256 +++++++++++++++++++++++++
 tb/tb_manchester_receiver.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/manchester_receiver_pkg.sv
// ----------------------------------------------------------------------------
// manchester_receiver_pkg
// Shared definitions for the Manchester frame link receiver: framing state
// encodings (also reported on o_status[11:8]), status word bit positions, the
// post-frame gap size shared with the transmitter, and a small LSB-first
// shift helper used by every byte-assembling state.
// ----------------------------------------------------------------------------
package manchester_receiver_pkg;

   // Framing states; numeric values are visible to the host through o_status.
   typedef enum logic [3:0] {
      ST_HUNT     = 4'd0,
      ST_PREAMBLE = 4'd1,
      ST_START    = 4'd2,
      ST_LEN0     = 4'd3,
      ST_LEN1     = 4'd4,
      ST_DATA     = 4'd5,
      ST_ERR      = 4'd6
   } rxState_e;

   // Sticky status bits in o_status[4:0].
   localparam int STAT_RX_OVERLAP  = 0;
   localparam int STAT_TIMEOUT     = 1;
   localparam int STAT_BAD_START   = 2;
   localparam int STAT_LEN_TOO_BIG = 3;
   localparam int STAT_LEN_ZERO    = 4;

   // Live state reporting in o_status.
   localparam int STAT_STATE_LSB   = 8;
   localparam int STAT_BUSY        = 12;

   // Line-low gap the transmitter leaves after each frame, in bit periods.
   localparam int GAP_BITS         = 2;

   // Shift one received bit into a byte that arrives LSB first.
   function automatic logic [7:0] shiftInLsbFirst(input logic [7:0] cur, input logic b);
      return {b, cur[7:1]};
   endfunction

endpackage

// File: rtl/manchester_receiver_bit_decoder.sv
// ----------------------------------------------------------------------------
// manchester_bit_decoder
// Recovers Manchester bits from the oversampled line. The line is brought
// into the clock domain by two flops, edges are found on the synchronised
// value, and only edges that land in the window where a mid-bit transition
// is expected are accepted. Edges too soon after the last mid-bit (bit
// boundaries, glitches) are blanked; no edge for too long raises a timeout.
//
// Ports
//   i_clk         sample clock, OVERSAMPLE cycles per line bit
//   i_rst_n       asynchronous active-low reset
//   i_rx          raw line input (asynchronous)
//   i_in_hunt     framing FSM is hunting: only falling edges count as bits
//   o_bit_stb     one-cycle strobe, a mid-bit edge was accepted
//   o_bit_val     decoded bit value for o_bit_stb (1 = rising, 0 = falling)
//   o_timeout_stb one-cycle strobe, expected mid-bit edge never arrived
// ----------------------------------------------------------------------------
module manchester_bit_decoder #(
   parameter int OVERSAMPLE = 8
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_rx,
   input  logic i_in_hunt,
   output logic o_bit_stb,
   output logic o_bit_val,
   output logic o_timeout_stb
);

   localparam int            CW      = $clog2(2 * OVERSAMPLE);
   localparam logic [CW-1:0] BLANK   = CW'(3 * OVERSAMPLE / 4);
   localparam logic [CW-1:0] TOUT    = CW'(5 * OVERSAMPLE / 4);
   localparam logic [CW-1:0] CNT_MAX = '1;

   logic          rxMeta_q;
   logic          rxSync_q;
   logic          rxPrev_q;
   logic          active_q;
   logic [CW-1:0] cnt_q;

   logic          edgeSeen;
   logic          inWindow;
   logic          accept;

   // cnt_q holds (cycles since the last accepted edge) - 1 at the moment an
   // edge is seen. While no bit is being tracked (after reset or timeout)
   // any qualifying edge is taken immediately so the decoder can lock on.
   always_comb begin
      edgeSeen = rxSync_q ^ rxPrev_q;
      inWindow = !active_q || ((cnt_q >= BLANK) && (cnt_q < TOUT));
      accept   = edgeSeen && inWindow && (!i_in_hunt || !rxSync_q);
   end

   assign o_bit_stb     = accept;
   assign o_bit_val     = rxSync_q;
   assign o_timeout_stb = active_q && (cnt_q == TOUT);

   // Synchroniser, edge history and the since-last-bit counter. The counter
   // saturates so a long idle line cannot wrap it back into the window.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rxMeta_q <= 1'b0;
         rxSync_q <= 1'b0;
         rxPrev_q <= 1'b0;
         active_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         rxMeta_q <= i_rx;
         rxSync_q <= rxMeta_q;
         rxPrev_q <= rxSync_q;
         if (accept) begin
            cnt_q    <= '0;
            active_q <= 1'b1;
         end else begin
            if (cnt_q != CNT_MAX) begin
               cnt_q <= cnt_q + 1'b1;
            end
            if (o_timeout_stb) begin
               active_q <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/manchester_receiver.sv
// ----------------------------------------------------------------------------
// manchester_receiver
// Receive side of the Manchester frame link. Bits recovered by
// manchester_bit_decoder drive a framing FSM that locks onto the preamble,
// checks the start bits, collects a 16-bit LSB-first length and then
// streams payload bytes out with a one-cycle valid strobe.
//
// Ports
//   i_clk           sample clock, OVERSAMPLE x bit rate
//   i_rst_n         asynchronous active-low reset
//   i_rx            line input, idle low
//   i_clear_status  clears the sticky bits o_status[4:0]
//   o_data          last received payload byte
//   o_data_valid    one-cycle strobe for o_data
//   o_frame_done    one-cycle strobe, whole frame received
//   o_frame_err     one-cycle strobe, frame aborted
//   o_frame_len     length field of the last frame
//   o_frames_count  good-frame counter, wraps
//   o_status        {3'b0, busy, state[3:0], 3'b0, sticky[4:0]}
// ----------------------------------------------------------------------------
module manchester_receiver
   import manchester_receiver_pkg::*;
#(
   parameter int OVERSAMPLE    = 8,
   parameter int MIN_PREAMBLE  = 16,
   parameter int MAX_FRAME_LEN = 1024
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_rx,
   input  logic        i_clear_status,
   output logic [7:0]  o_data,
   output logic        o_data_valid,
   output logic        o_frame_done,
   output logic        o_frame_err,
   output logic [15:0] o_frame_len,
   output logic [7:0]  o_frames_count,
   output logic [15:0] o_status
);

   localparam int            ZW         = $clog2(MIN_PREAMBLE + 1);
   localparam logic [ZW-1:0] ZERO_SAT   = ZW'(MIN_PREAMBLE);
   localparam int            GW         = $clog2(GAP_BITS * OVERSAMPLE + 1);
   localparam logic [GW-1:0] GAP_CYCLES = GW'(GAP_BITS * OVERSAMPLE);
   localparam logic [15:0]   MAX_LEN    = 16'(MAX_FRAME_LEN);

   logic           bitStb;
   logic           bitVal;
   logic           timeoutStb;

   rxState_e       state_q;
   logic [ZW-1:0]  zeroCnt_q;
   logic [2:0]     bitCnt_q;
   logic [7:0]     shift_q;
   logic [7:0]     lenLo_q;
   logic [15:0]    byteCnt_q;
   logic [GW-1:0]  gapCnt_q;
   logic [4:0]     sticky_q;
   logic [3:0]     stateReg_q;
   logic           busy_q;
   logic [7:0]     data_q;
   logic           dataValid_q;
   logic           frameDone_q;
   logic           frameErr_q;
   logic [15:0]    frameLen_q;
   logic [7:0]     framesCount_q;

   logic [7:0]     byte_d;
   logic [15:0]    len_d;
   logic [15:0]    status_d;

   manchester_bit_decoder #(
      .OVERSAMPLE(OVERSAMPLE)
   ) u_bitDecoder (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_rx         (i_rx),
      .i_in_hunt    (state_q == ST_HUNT),
      .o_bit_stb    (bitStb),
      .o_bit_val    (bitVal),
      .o_timeout_stb(timeoutStb)
   );

   // The byte being completed by the current bit, and the full length field
   // as it would read if this bit closes LEN1.
   always_comb begin
      byte_d = shiftInLsbFirst(shift_q, bitVal);
      len_d  = {byte_d, lenLo_q};
   end

   // Framing FSM. All host-visible outputs are registered here; strobes
   // default low every cycle. The status snapshot of state lags by one
   // cycle. A clear request and a sticky event in the same cycle leave the
   // event bit set because the later assignment wins.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= ST_HUNT;
         zeroCnt_q     <= '0;
         bitCnt_q      <= '0;
         shift_q       <= '0;
         lenLo_q       <= '0;
         byteCnt_q     <= '0;
         gapCnt_q      <= '0;
         sticky_q      <= '0;
         stateReg_q    <= '0;
         busy_q        <= 1'b0;
         data_q        <= '0;
         dataValid_q   <= 1'b0;
         frameDone_q   <= 1'b0;
         frameErr_q    <= 1'b0;
         frameLen_q    <= '0;
         framesCount_q <= '0;
      end else begin
         dataValid_q <= 1'b0;
         frameDone_q <= 1'b0;
         frameErr_q  <= 1'b0;
         stateReg_q  <= state_q;
         busy_q      <= (state_q != ST_HUNT);
         if (gapCnt_q != '0) begin
            gapCnt_q <= gapCnt_q - 1'b1;
         end
         if (i_clear_status) begin
            sticky_q <= '0;
         end

         case (state_q)
            ST_HUNT: begin
               if (bitStb) begin
                  state_q   <= ST_PREAMBLE;
                  zeroCnt_q <= ZW'(1);
                  // A new frame starting inside the post-frame gap means the
                  // transmitter did not respect the line-low interval.
                  if (gapCnt_q != '0) begin
                     sticky_q[STAT_RX_OVERLAP] <= 1'b1;
                  end
               end
            end

            ST_PREAMBLE: begin
               if (bitStb) begin
                  if (!bitVal) begin
                     if (zeroCnt_q != ZERO_SAT) begin
                        zeroCnt_q <= zeroCnt_q + 1'b1;
                     end
                  end else if (zeroCnt_q >= ZERO_SAT) begin
                     state_q <= ST_START;
                  end else begin
                     state_q <= ST_HUNT;
                  end
               end else if (timeoutStb) begin
                  state_q <= ST_HUNT;
               end
            end

            ST_START: begin
               if (bitStb) begin
                  if (bitVal) begin
                     state_q  <= ST_LEN0;
                     bitCnt_q <= '0;
                  end else begin
                     state_q                  <= ST_ERR;
                     sticky_q[STAT_BAD_START] <= 1'b1;
                  end
               end else if (timeoutStb) begin
                  state_q                <= ST_ERR;
                  sticky_q[STAT_TIMEOUT] <= 1'b1;
               end
            end

            ST_LEN0: begin
               if (bitStb) begin
                  shift_q  <= byte_d;
                  bitCnt_q <= bitCnt_q + 1'b1;
                  if (bitCnt_q == 3'd7) begin
                     lenLo_q <= byte_d;
                     state_q <= ST_LEN1;
                  end
               end else if (timeoutStb) begin
                  state_q                <= ST_ERR;
                  sticky_q[STAT_TIMEOUT] <= 1'b1;
               end
            end

            ST_LEN1: begin
               if (bitStb) begin
                  shift_q  <= byte_d;
                  bitCnt_q <= bitCnt_q + 1'b1;
                  if (bitCnt_q == 3'd7) begin
                     frameLen_q <= len_d;
                     byteCnt_q  <= '0;
                     if (len_d == 16'd0) begin
                        state_q                 <= ST_ERR;
                        sticky_q[STAT_LEN_ZERO] <= 1'b1;
                     end else if (len_d > MAX_LEN) begin
                        state_q                    <= ST_ERR;
                        sticky_q[STAT_LEN_TOO_BIG] <= 1'b1;
                     end else begin
                        state_q <= ST_DATA;
                     end
                  end
               end else if (timeoutStb) begin
                  state_q                <= ST_ERR;
                  sticky_q[STAT_TIMEOUT] <= 1'b1;
               end
            end

            ST_DATA: begin
               if (bitStb) begin
                  shift_q  <= byte_d;
                  bitCnt_q <= bitCnt_q + 1'b1;
                  if (bitCnt_q == 3'd7) begin
                     data_q      <= byte_d;
                     dataValid_q <= 1'b1;
                     byteCnt_q   <= byteCnt_q + 16'd1;
                     if (byteCnt_q + 16'd1 == frameLen_q) begin
                        frameDone_q   <= 1'b1;
                        framesCount_q <= framesCount_q + 8'd1;
                        gapCnt_q      <= GAP_CYCLES;
                        state_q       <= ST_HUNT;
                     end
                  end
               end else if (timeoutStb) begin
                  state_q                <= ST_ERR;
                  sticky_q[STAT_TIMEOUT] <= 1'b1;
               end
            end

            ST_ERR: begin
               frameErr_q <= 1'b1;
               state_q    <= ST_HUNT;
            end

            default: begin
               state_q <= ST_HUNT;
            end
         endcase
      end
   end

   // Status word assembled from registered fields only.
   always_comb begin
      status_d                            = '0;
      status_d[STAT_BUSY]                 = busy_q;
      status_d[STAT_STATE_LSB +: 4]       = stateReg_q;
      status_d[STAT_LEN_ZERO:STAT_RX_OVERLAP] = sticky_q;
   end

   assign o_data         = data_q;
   assign o_data_valid   = dataValid_q;
   assign o_frame_done   = frameDone_q;
   assign o_frame_err    = frameErr_q;
   assign o_frame_len    = frameLen_q;
   assign o_frames_count = framesCount_q;
   assign o_status       = status_d;

endmodule

// File: tb/tb_manchester_receiver.sv
// ----------------------------------------------------------------------------
// tb_manchester_receiver
// Directed bench for manchester_receiver with OVERSAMPLE=8. The line is
// driven on falling clock edges, one Manchester bit per 8 cycles; a monitor
// on the falling edge records strobes, received bytes and strobe times.
// ----------------------------------------------------------------------------
module tb_manchester_receiver;

   localparam int OS = 8;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_rx;
   logic        i_clear_status;
   logic [7:0]  o_data;
   logic        o_data_valid;
   logic        o_frame_done;
   logic        o_frame_err;
   logic [15:0] o_frame_len;
   logic [7:0]  o_frames_count;
   logic [15:0] o_status;

   int          errors = 0;
   int          checks = 0;

   logic [7:0]  rxBytes[$];
   int          validCnt = 0;
   int          doneCnt  = 0;
   int          errCnt   = 0;
   time         validTime = 0;
   time         doneTime  = 0;
   time         errTime   = 0;
   time         lastMidTime = 0;

   logic [7:0]  txBytes[0:7];

   int          b0;
   int          v0;
   int          d0;
   int          e0;

   manchester_receiver #(
      .OVERSAMPLE   (OS),
      .MIN_PREAMBLE (16),
      .MAX_FRAME_LEN(1024)
   ) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_rx          (i_rx),
      .i_clear_status(i_clear_status),
      .o_data        (o_data),
      .o_data_valid  (o_data_valid),
      .o_frame_done  (o_frame_done),
      .o_frame_err   (o_frame_err),
      .o_frame_len   (o_frame_len),
      .o_frames_count(o_frames_count),
      .o_status      (o_status)
   );

   // 10-unit clock period.
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Output monitor, sampling mid-cycle.
   always @(negedge i_clk) begin
      if (o_data_valid) begin
         rxBytes.push_back(o_data);
         validCnt++;
         validTime = $time;
      end
      if (o_frame_done) begin
         doneCnt++;
         doneTime = $time;
      end
      if (o_frame_err) begin
         errCnt++;
         errTime = $time;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] getByte(input int idx);
      if (idx < rxBytes.size()) return rxBytes[idx];
      return 8'hxx;
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge i_clk);
         i_rx = 1'b0;
      end
   endtask

   // One Manchester bit; optional 2-cycle glitch a quarter bit after mid-bit.
   task automatic sendBit(input logic b, input bit glitch);
      for (int ph = 0; ph < OS; ph++) begin
         @(negedge i_clk);
         i_rx = (ph < OS / 2) ? ~b : b;
         if (ph == OS / 2) lastMidTime = $time;
         if (glitch && (ph == 5 || ph == 6)) i_rx = ~i_rx;
      end
   endtask

   task automatic sendByte(input logic [7:0] v, input bit glitch);
      for (int i = 0; i < 8; i++) sendBit(v[i], glitch);
   endtask

   // Preamble zeros, two start ones, 16-bit length, then txBytes[0..nBytes-1].
   task automatic applyStimulus(input int nPre, input logic [15:0] len, input int nBytes, input bit glitch);
      for (int i = 0; i < nPre; i++) sendBit(1'b0, 1'b0);
      sendBit(1'b1, 1'b0);
      sendBit(1'b1, 1'b0);
      sendByte(len[7:0], 1'b0);
      sendByte(len[15:8], 1'b0);
      for (int i = 0; i < nBytes; i++) sendByte(txBytes[i], glitch);
   endtask

   task automatic snapshot();
      b0 = rxBytes.size();
      v0 = validCnt;
      d0 = doneCnt;
      e0 = errCnt;
   endtask

   initial begin
      i_rst_n        = 1'b0;
      i_rx           = 1'b0;
      i_clear_status = 1'b0;
      for (int i = 0; i < 8; i++) txBytes[i] = 8'h00;
      repeat (3) @(negedge i_clk);

      $display("[TB] reset state");
      checkOutput("reset_status", 32'(o_status), 32'h0);
      checkOutput("reset_frames", 32'(o_frames_count), 32'h0);
      checkOutput("reset_len", 32'(o_frame_len), 32'h0);
      checkOutput("reset_data", {o_data, o_data_valid, o_frame_done, o_frame_err}, 32'h0);
      i_rst_n = 1'b1;
      idle(20);

      $display("[TB] good frame len=3 A5 01 FF");
      snapshot();
      txBytes[0] = 8'hA5; txBytes[1] = 8'h01; txBytes[2] = 8'hFF;
      applyStimulus(64, 16'd3, 3, 1'b0);
      idle(40);
      checkOutput("f1_nvalid", 32'(validCnt - v0), 32'd3);
      checkOutput("f1_byte0", 32'(getByte(b0)), 32'hA5);
      checkOutput("f1_byte1", 32'(getByte(b0 + 1)), 32'h01);
      checkOutput("f1_byte2", 32'(getByte(b0 + 2)), 32'hFF);
      checkOutput("f1_done", 32'(doneCnt - d0), 32'd1);
      checkOutput("f1_err", 32'(errCnt - e0), 32'd0);
      checkOutput("f1_frames", 32'(o_frames_count), 32'd1);
      checkOutput("f1_len", 32'(o_frame_len), 32'd3);
      checkOutput("f1_status", 32'(o_status), 32'h0);
      checkOutput("f1_latency", 32'(validTime - lastMidTime), 32'd30);
      checkOutput("f1_done_with_valid", 32'(doneTime - validTime), 32'd0);

      $display("[TB] short preamble");
      snapshot();
      for (int i = 0; i < 8; i++) sendBit(1'b0, 1'b0);
      sendBit(1'b1, 1'b0);
      sendBit(1'b1, 1'b0);
      idle(40);
      checkOutput("sp_strobes", 32'((validCnt - v0) + (doneCnt - d0) + (errCnt - e0)), 32'd0);
      checkOutput("sp_status", 32'(o_status), 32'h0);
      checkOutput("sp_frames", 32'(o_frames_count), 32'd1);

      $display("[TB] zero length");
      snapshot();
      applyStimulus(32, 16'h0000, 0, 1'b0);
      idle(40);
      checkOutput("z_err", 32'(errCnt - e0), 32'd1);
      checkOutput("z_nvalid", 32'(validCnt - v0), 32'd0);
      checkOutput("z_status", 32'(o_status), 32'h0010);
      @(negedge i_clk); i_clear_status = 1'b1;
      @(negedge i_clk); i_clear_status = 1'b0;
      idle(2);
      checkOutput("z_cleared", 32'(o_status), 32'h0);

      $display("[TB] line dropped mid-payload");
      snapshot();
      txBytes[0] = 8'h12; txBytes[1] = 8'h34;
      applyStimulus(32, 16'd5, 2, 1'b0);
      idle(40);
      checkOutput("t_nvalid", 32'(validCnt - v0), 32'd2);
      checkOutput("t_byte0", 32'(getByte(b0)), 32'h12);
      checkOutput("t_byte1", 32'(getByte(b0 + 1)), 32'h34);
      checkOutput("t_err", 32'(errCnt - e0), 32'd1);
      checkOutput("t_err_delay_ok", 32'((errTime - lastMidTime >= 100) && (errTime - lastMidTime <= 160)), 32'd1);
      checkOutput("t_status", 32'(o_status), 32'h0002);
      checkOutput("t_len", 32'(o_frame_len), 32'd5);
      @(negedge i_clk); i_clear_status = 1'b1;
      @(negedge i_clk); i_clear_status = 1'b0;
      idle(20);

      $display("[TB] glitched payload");
      snapshot();
      txBytes[0] = 8'h5A; txBytes[1] = 8'hC3;
      applyStimulus(32, 16'd2, 2, 1'b1);
      idle(40);
      checkOutput("g_nvalid", 32'(validCnt - v0), 32'd2);
      checkOutput("g_byte0", 32'(getByte(b0)), 32'h5A);
      checkOutput("g_byte1", 32'(getByte(b0 + 1)), 32'hC3);
      checkOutput("g_err", 32'(errCnt - e0), 32'd0);
      checkOutput("g_frames", 32'(o_frames_count), 32'd2);
      checkOutput("g_status", 32'(o_status), 32'h0);

      $display("[TB] reset mid-frame");
      snapshot();
      txBytes[0] = 8'h77;
      applyStimulus(32, 16'd4, 1, 1'b0);
      sendBit(1'b1, 1'b0);
      sendBit(1'b0, 1'b0);
      @(negedge i_clk);
      i_rst_n = 1'b0;
      i_rx    = 1'b0;
      repeat (3) @(negedge i_clk);
      checkOutput("r_frames", 32'(o_frames_count), 32'd0);
      checkOutput("r_status", 32'(o_status), 32'h0);
      checkOutput("r_data", 32'(o_data), 32'h0);
      i_rst_n = 1'b1;
      idle(40);
      checkOutput("r_no_err", 32'(errCnt - e0), 32'd0);
      snapshot();
      txBytes[0] = 8'h3C;
      applyStimulus(32, 16'd1, 1, 1'b0);
      idle(40);
      checkOutput("r_nvalid", 32'(validCnt - v0), 32'd1);
      checkOutput("r_byte", 32'(getByte(b0)), 32'h3C);
      checkOutput("r_done", 32'(doneCnt - d0), 32'd1);
      checkOutput("r_frames_after", 32'(o_frames_count), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
